// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite SRAM responder: response codes and channel FSM states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_bytewise.sv
// Word array with one combinational read port and one synchronous byte-enabled write port.
// Latency: read is same-cycle combinational, write lands on the clock edge.
// Backpressure: none; the caller decides when to read or write.
module sram_bytewise #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int IW        = $clog2(DEPTH),
  localparam int SW        = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic [IW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [SW-1:0]         i_wstrb
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_raddr];

  // Contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite responder over a byte-strobed word SRAM, one outstanding read and one outstanding write.
// Latency: rvalid RD_LAT edges after AR, bvalid WR_LAT edges after the later of AW/W.
// Backpressure: rvalid/bvalid hold with stable payload until rready/bready; AR/AW/W stall meanwhile.
module axi_lite_sram
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
  parameter int                    DEPTH      = 1024,
  parameter int                    RD_LAT     = 1,
  parameter int                    WR_LAT     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(max_lat(RD_LAT, WR_LAT) + 1);
  localparam logic [ADDR_WIDTH:0] SPAN    = (ADDR_WIDTH+1)'(4 * DEPTH);
  localparam logic [CW-1:0]       RD_LOAD = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [CW-1:0]       WR_LOAD = CW'((WR_LAT > 1) ? WR_LAT - 2 : 0);

  // Address decode: full-width offset compare covers both the below-BASE and past-end cases.
  logic [ADDR_WIDTH-1:0] w_ar_off, w_aw_off;
  logic                  w_ar_ok, w_aw_ok;
  logic [IW-1:0]         w_ar_idx, w_aw_idx;

  assign w_ar_off = i_araddr - BASE;
  assign w_aw_off = i_awaddr - BASE;
  assign w_ar_ok  = (i_araddr >= BASE) && ({1'b0, w_ar_off} < SPAN);
  assign w_aw_ok  = (i_awaddr >= BASE) && ({1'b0, w_aw_off} < SPAN);
  assign w_ar_idx = w_ar_off[IW+1:2];
  assign w_aw_idx = w_aw_off[IW+1:2];

  rd_state_t             r_rstate;
  logic [CW-1:0]         r_rcnt;
  logic [IW-1:0]         r_ar_idx;
  logic                  r_ar_ok;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_t                 r_rresp;

  wr_state_t             r_wstate;
  logic [CW-1:0]         r_wcnt;
  logic                  r_got_aw, r_got_w;
  logic [IW-1:0]         r_aw_idx;
  logic                  r_aw_ok;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic                  r_awready, r_wready;
  logic                  r_bvalid;
  resp_t                 r_bresp;

  logic [IW-1:0]         w_sram_raddr;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic                  w_aw_hs, w_w_hs, w_got_aw_nx, w_got_w_nx;
  logic [IW-1:0]         w_aw_idx_eff;
  logic                  w_aw_ok_eff;
  logic [DATA_WIDTH-1:0] w_wdata_eff;
  logic [SW-1:0]         w_wstrb_eff;
  logic                  w_commit;

  // With RD_LAT=1 the sample happens on the AR edge itself, so read the incoming index while idle.
  assign w_sram_raddr = (r_rstate == R_IDLE) ? w_ar_idx : r_ar_idx;

  assign w_aw_hs      = i_awvalid & r_awready;
  assign w_w_hs       = i_wvalid & r_wready;
  assign w_got_aw_nx  = r_got_aw | w_aw_hs;
  assign w_got_w_nx   = r_got_w | w_w_hs;
  assign w_aw_idx_eff = r_got_aw ? r_aw_idx : w_aw_idx;
  assign w_aw_ok_eff  = r_got_aw ? r_aw_ok : w_aw_ok;
  assign w_wdata_eff  = r_got_w ? r_wdata : i_wdata;
  assign w_wstrb_eff  = r_got_w ? r_wstrb : i_wstrb;
  assign w_commit     = ((r_wstate == W_IDLE) && w_got_aw_nx && w_got_w_nx && (WR_LAT == 1)) ||
                        ((r_wstate == W_WAIT) && (r_wcnt == '0));

  sram_bytewise #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_raddr (w_sram_raddr),
    .o_rdata (w_mem_rdata),
    .i_we    (w_commit & w_aw_ok_eff),
    .i_waddr (w_aw_idx_eff),
    .i_wdata (w_wdata_eff),
    .i_wstrb (w_wstrb_eff)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= '0;
      r_ar_idx  <= '0;
      r_ar_ok   <= 1'b0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (i_arvalid) begin
            r_ar_idx  <= w_ar_idx;
            r_ar_ok   <= w_ar_ok;
            r_arready <= 1'b0;
            if (RD_LAT == 1) begin
              r_rstate <= R_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= w_ar_ok ? w_mem_rdata : '0;
              r_rresp  <= w_ar_ok ? OKAY : SLVERR;
            end else begin
              r_rstate <= R_WAIT;
              r_rcnt   <= RD_LOAD;
            end
          end
        end
        R_WAIT: begin
          if (r_rcnt == '0) begin
            r_rstate <= R_RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= r_ar_ok ? w_mem_rdata : '0;
            r_rresp  <= r_ar_ok ? OKAY : SLVERR;
          end else begin
            r_rcnt <= r_rcnt - CW'(1);
          end
        end
        R_RESP: begin
          if (i_rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate  <= W_IDLE;
      r_wcnt    <= '0;
      r_got_aw  <= 1'b0;
      r_got_w   <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_ok   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_got_aw  <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_ok   <= w_aw_ok;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_got_w  <= 1'b1;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
            r_wready <= 1'b0;
          end
          if (w_got_aw_nx && w_got_w_nx) begin
            if (WR_LAT == 1) begin
              r_wstate <= W_RESP;
              r_bvalid <= 1'b1;
              r_bresp  <= w_aw_ok_eff ? OKAY : SLVERR;
            end else begin
              r_wstate <= W_WAIT;
              r_wcnt   <= WR_LOAD;
            end
          end
        end
        W_WAIT: begin
          if (r_wcnt == '0) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_ok ? OKAY : SLVERR;
          end else begin
            r_wcnt <= r_wcnt - CW'(1);
          end
        end
        W_RESP: begin
          if (i_bready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_got_aw  <= 1'b0;
            r_got_w   <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: directed plan items plus randomized traffic against a word-map model.
module tb_axi_lite_sram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          RD_A  = 3;
  localparam int          WR_A  = 2;
  localparam int          RD_B  = 4;
  localparam int          WR_B  = 4;

  logic clk;
  logic rst_a_n, rst_b_n;

  logic [31:0] a_araddr, a_awaddr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_rresp, a_bresp;
  logic a_arvalid, a_arready, a_rvalid, a_rready;
  logic a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;

  logic [31:0] b_araddr, b_awaddr, b_wdata, b_rdata;
  logic [3:0]  b_wstrb;
  logic [1:0]  b_rresp, b_bresp;
  logic b_arvalid, b_arready, b_rvalid, b_rready;
  logic b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;

  int checks = 0;
  int errors = 0;

  bit [31:0] model [int];

  axi_lite_sram #(.BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_A), .WR_LAT(WR_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n),
    .i_araddr(a_araddr), .i_arvalid(a_arvalid), .o_arready(a_arready),
    .o_rdata(a_rdata), .o_rresp(a_rresp), .o_rvalid(a_rvalid), .i_rready(a_rready),
    .i_awaddr(a_awaddr), .i_awvalid(a_awvalid), .o_awready(a_awready),
    .i_wdata(a_wdata), .i_wstrb(a_wstrb), .i_wvalid(a_wvalid), .o_wready(a_wready),
    .o_bresp(a_bresp), .o_bvalid(a_bvalid), .i_bready(a_bready)
  );

  axi_lite_sram #(.BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_B), .WR_LAT(WR_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n),
    .i_araddr(b_araddr), .i_arvalid(b_arvalid), .o_arready(b_arready),
    .o_rdata(b_rdata), .o_rresp(b_rresp), .o_rvalid(b_rvalid), .i_rready(b_rready),
    .i_awaddr(b_awaddr), .i_awvalid(b_awvalid), .o_awready(b_awready),
    .i_wdata(b_wdata), .i_wstrb(b_wstrb), .i_wvalid(b_wvalid), .o_wready(b_wready),
    .o_bresp(b_bresp), .o_bvalid(b_bvalid), .i_bready(b_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_bound(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic bit in_range(input logic [31:0] addr);
    longint a = longint'(addr);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    if (!in_range(addr)) return 32'h0;
    return model[word_of(addr)];
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
    return in_range(addr) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit [31:0] w;
    if (!in_range(addr)) return;
    w = model.exists(word_of(addr)) ? model[word_of(addr)] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
    model[word_of(addr)] = w;
  endtask

  // w_lead > 0: W presented that many cycles before AW; < 0: AW leads.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int b_delay, output logic [1:0] resp, output int lat);
    int  aw_start, w_start, c;
    bit  aw_done, w_done, hs_aw, hs_w;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; c = 0;
    a_awaddr = addr; a_wdata = data; a_wstrb = strb;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (w_done && !aw_done) begin
        check("wready_after_w", a_wready, 0);
        check("awready_while_w_held", a_awready, 1);
      end
      if (aw_done && !w_done) begin
        check("awready_after_aw", a_awready, 0);
        check("wready_while_aw_held", a_wready, 1);
      end
      a_awvalid = (c >= aw_start) && !aw_done;
      a_wvalid  = (c >= w_start) && !w_done;
      hs_aw = a_awvalid && a_awready;
      hs_w  = a_wvalid && a_wready;
      @(posedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      c++;
      if (c > 50) begin fail_bound("aw_w_accept"); break; end
    end
    @(negedge clk);
    a_awvalid = 0; a_wvalid = 0;
    lat = 1;
    while (!a_bvalid && lat < 20) begin @(negedge clk); lat++; end
    resp = a_bresp;
    repeat (b_delay) begin
      @(negedge clk);
      check("bvalid_hold", a_bvalid, 1);
      check("bresp_hold", a_bresp, resp);
    end
    a_bready = 1;
    @(posedge clk);
    @(negedge clk);
    a_bready = 0;
    check("bvalid_drop", a_bvalid, 0);
    check("awready_back", a_awready, 1);
    check("wready_back", a_wready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    a_araddr = addr; a_arvalid = 1;
    n = 0;
    while (!a_arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail_bound("ar_accept");
    @(posedge clk);
    @(negedge clk);
    a_arvalid = 0;
    lat = 1;
    while (!a_rvalid && lat < 20) begin @(negedge clk); lat++; end
    data = a_rdata; resp = a_rresp;
    check("arready_busy", a_arready, 0);
    repeat (stall) begin
      @(negedge clk);
      check("rvalid_hold", a_rvalid, 1);
      check("rdata_hold", a_rdata, data);
      check("rresp_hold", a_rresp, resp);
      check("arready_stall", a_arready, 0);
    end
    a_rready = 1;
    @(posedge clk);
    @(negedge clk);
    a_rready = 0;
    check("arready_next", a_arready, 1);
    check("rvalid_drop", a_rvalid, 0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input int stall);
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(addr, stall, d, r, lat);
    check({tag, "_rdata"}, d, exp_rdata(addr));
    check({tag, "_rresp"}, r, exp_resp(addr));
    check({tag, "_rlat"}, lat, RD_A);
  endtask

  task automatic wr_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input int b_delay);
    logic [1:0] r; int lat;
    do_write(addr, data, strb, w_lead, b_delay, r, lat);
    check({tag, "_bresp"}, r, exp_resp(addr));
    check({tag, "_wlat"}, lat, WR_A);
    model_write(addr, data, strb);
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [3:0]  strb;
    int          lat, sel;

    rst_a_n = 0; rst_b_n = 0;
    a_araddr = 0; a_arvalid = 0; a_rready = 0; a_awaddr = 0; a_awvalid = 0;
    a_wdata = 0; a_wstrb = 0; a_wvalid = 0; a_bready = 0;
    b_araddr = 0; b_arvalid = 0; b_rready = 0; b_awaddr = 0; b_awvalid = 0;
    b_wdata = 0; b_wstrb = 0; b_wvalid = 0; b_bready = 0;
    repeat (3) @(negedge clk);
    rst_a_n = 1; rst_b_n = 1;
    @(negedge clk);
    check("rst_arready", a_arready, 1);
    check("rst_awready", a_awready, 1);
    check("rst_wready", a_wready, 1);
    check("rst_rvalid", a_rvalid, 0);
    check("rst_bvalid", a_bvalid, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_rresp", a_rresp, 0);
    check("rst_bresp", a_bresp, 0);

    wr_check("full_wr", BASE, 32'hDEADBEEF, 4'hF, 0, 0);
    rd_check("full_rd", BASE, 0);

    wr_check("part_wr0", BASE + 4, 32'h11223344, 4'hF, 0, 1);
    wr_check("part_wr1", BASE + 4, 32'hAABBCCDD, 4'b0101, 0, 0);
    rd_check("part_rd", BASE + 4, 0);
    check("part_const", exp_rdata(BASE + 4), 32'h11BB33DD);

    wr_check("w_lead3", BASE + 8, 32'h0BADF00D, 4'hF, 3, 0);
    wr_check("aw_lead2", BASE + 12, 32'h13572468, 4'hF, -2, 2);
    rd_check("w_lead3_rd", BASE + 8, 1);

    rd_check("bp_rd", BASE, 5);

    rd_check("oor_rd", 32'h7FFF_FFFC, 0);
    check("oor_const", exp_resp(32'h7FFF_FFFC), 2'b10);
    wr_check("edge_wr", BASE + 32'hFFC, 32'h5A5A5A5A, 4'hF, 0, 0);
    wr_check("oor_wr", BASE + 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 0);
    rd_check("edge_rd", BASE + 32'hFFC, 0);
    rd_check("alias_rd", BASE, 0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = BASE + 32'(4 * sel * 97) + 32'($urandom_range(0, 3));
      else if (sel == 7) addr = BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
      else if (sel == 8) addr = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else               addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && (!in_range(addr) || model.exists(word_of(addr)))) begin
        rd_check("rnd_rd", addr, $urandom_range(0, 2));
      end else begin
        data = $urandom;
        strb = (in_range(addr) && model.exists(word_of(addr))) ? 4'($urandom_range(0, 15)) : 4'hF;
        wr_check("rnd_wr", addr, data, strb, $urandom_range(0, 6) - 3, $urandom_range(0, 2));
      end
    end

    // Second instance: reset while both channels sit in their wait states.
    @(negedge clk);
    b_awaddr = BASE + 16; b_wdata = 32'hCAFEF00D; b_wstrb = 4'hF;
    b_awvalid = 1; b_wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    b_awvalid = 0; b_wvalid = 0;
    lat = 1;
    while (!b_bvalid && lat < 20) begin @(negedge clk); lat++; end
    check("b_wlat", lat, WR_B);
    check("b_bresp", b_bresp, 0);
    b_bready = 1;
    @(posedge clk);
    @(negedge clk);
    b_bready = 0;

    b_araddr = BASE + 16; b_arvalid = 1;
    b_awaddr = BASE + 16; b_wdata = 32'h12345678; b_awvalid = 1; b_wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    b_arvalid = 0; b_awvalid = 0; b_wvalid = 0;
    check("b_wait_rvalid", b_rvalid, 0);
    check("b_wait_bvalid", b_bvalid, 0);
    @(posedge clk);
    #2 rst_b_n = 0;
    #1;
    check("b_rst_arready", b_arready, 1);
    check("b_rst_rvalid", b_rvalid, 0);
    repeat (2) @(negedge clk);
    rst_b_n = 1;
    repeat (6) begin
      @(negedge clk);
      check("b_post_rvalid", b_rvalid, 0);
      check("b_post_bvalid", b_bvalid, 0);
    end
    check("b_post_arready", b_arready, 1);
    check("b_post_awready", b_awready, 1);
    check("b_post_wready", b_wready, 1);

    b_araddr = BASE + 16; b_arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    b_arvalid = 0;
    lat = 1;
    while (!b_rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("b_rlat", lat, RD_B);
    check("b_no_commit", b_rdata, 32'hCAFEF00D);
    check("b_rresp", b_rresp, 0);
    b_rready = 1;
    @(posedge clk);
    @(negedge clk);
    b_rready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
